snake_stream_monitor: RTL and testbench
=======================================

Name: snake_stream_monitor

Overview:
- Receiver and checker for the circulating snake body stream (pos_x/pos_y/first/last/valid) that the snake block emits and the apple and vga blocks consume.
- Frames each lap of the stream and counts segments per lap.
- Detects head-vs-body overlap and head-register mismatches.
- Flags framing violations, giving verification and debug logic an independent observer of the stream.

Parameters:
- X_W, 5, width of the x coordinate (32 columns).
- Y_W, 4, width of the y coordinate (16 rows).
- MAX_LEN, 512, maximum legal segments per lap.
- LEN_W, 10, width of o_length; must satisfy 2^LEN_W > MAX_LEN.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous, active-low reset.
- i_pos_x  in  X_W  segment x.
- i_pos_y  in  Y_W  segment y.
- i_pos_first  in  1  beat is the head segment.
- i_pos_last  in  1  beat is the tail segment.
- i_pos_valid  in  1  beat qualifier; other pos inputs are don't-care when low.
- i_head_x  in  X_W  snake head register x.
- i_head_y  in  Y_W  snake head register y.
- o_synced  out  1  monitor is inside a framed lap.
- o_lap_done  out  1  one-cycle pulse; a lap completed cleanly.
- o_length  out  LEN_W  segment count of the last completed lap.
- o_self_hit  out  1  last completed lap had a body segment equal to the head.
- o_head_mismatch  out  1  last completed lap's first beat differed from i_head_x/i_head_y.
- o_proto_err  out  1  one-cycle pulse on a framing violation.

Behaviour:
- Reset (rst_n low at a clk edge):
  - state SYNC; all outputs 0; internal count, latched head and sticky flags cleared.
  - Reset mid-lap discards the lap; no o_lap_done and no o_proto_err is produced for it.
- Only beats with i_pos_valid=1 are processed. Idle cycles (valid=0) inside a lap are legal and change nothing.
- States:
  - SYNC: waiting for a first beat.
  - LAP: a lap is being framed.
- SYNC transitions:
  - valid & first: latch pos as head; count=1; hit=0; mismatch=(pos != {i_head_x,i_head_y}) sampled that cycle; go to LAP.
  - If that beat also has last (length-1 snake): complete the lap immediately and stay in SYNC.
  - valid & !first: ignored; no error raised, since monitor start is asynchronous to the stream.
- LAP, valid & !first:
  - count += 1.
  - hit |= (pos == latched head).
  - If last: complete the lap and go to SYNC.
- LAP, valid & first (first without a preceding last):
  - o_proto_err pulses next cycle.
  - The beat restarts a lap exactly as from SYNC; stay in LAP, or complete immediately if last is also set.
- LAP, count reaches MAX_LEN and the next beat is valid & !first:
  - o_proto_err pulses; go to SYNC.
  - count never exceeds MAX_LEN.
- Lap completion, registered with 1-cycle latency after the beat carrying last:
  - o_lap_done=1 for exactly one cycle.
  - o_length=count including the last beat.
  - o_self_hit=hit; o_head_mismatch=mismatch.
  - These values hold until the next completion or reset.
- o_synced=1 exactly while in LAP.
- Simultaneous first & last beats back-to-back give consecutive o_lap_done pulses with o_length=1 each.
- Comparisons are full-width equality on {x,y}; no wrap-around arithmetic is involved.

Decomposition:
- Shared package snake_pkg:
  - constants GRID_X_W=5, GRID_Y_W=4, SNAKE_MAX_LEN=512.
  - typedef pos_t as a packed {x,y} struct.
  - enum mon_state_t {SYNC, LAP}.
- Single module; no sub-module is warranted. Segment counter and comparator stay inline.

Test Plan:
- Reset then stream (10,5)F,(9,5),(8,5)L with head=(10,5) -> o_lap_done pulse 1 cycle after L; o_length=3, o_self_hit=0, o_head_mismatch=0.
- Single beat (3,3) with F&L, head=(3,3), repeated on 3 consecutive cycles -> o_lap_done high on 3 consecutive cycles; o_length=1 each time.
- Lap (4,4)F,(5,4),(5,5),(4,5),(4,4)L -> o_length=5, o_self_hit=1.
- (1,1)F,(2,1), then (7,7)F,(6,7)L -> o_proto_err pulse after the second F; next o_length=2 from the restarted lap.
- Monitor starts mid-stream with 2 non-first beats, then inserts valid=0 gaps within a 4-beat lap and sets head register=(0,0) while the first beat is (1,0) -> no error on the orphan beats; o_length=4, o_head_mismatch=1.
- MAX_LEN=4 override: 5 beats without last -> o_proto_err on the 5th beat, o_synced=0; assert rst_n=0 mid-lap in a separate run -> all outputs 0, no pulse.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared definitions for the snake body stream and its observers.
package snake_pkg;

    localparam int GRID_X_W      = 5;
    localparam int GRID_Y_W      = 4;
    localparam int SNAKE_MAX_LEN = 512;

    typedef struct packed {
        logic [GRID_X_W-1:0] x;
        logic [GRID_Y_W-1:0] y;
    } pos_t;

    typedef enum logic {
        SYNC,
        LAP
    } mon_state_t;

endpackage

// File: rtl/snake_stream_monitor.sv
// Independent observer of the circulating snake body stream: frames each
// lap, counts segments, checks the head against the body and the head
// register, and reports framing violations.
module snake_stream_monitor
    import snake_pkg::*;
#(
    parameter int X_W     = GRID_X_W,
    parameter int Y_W     = GRID_Y_W,
    parameter int MAX_LEN = SNAKE_MAX_LEN,
    parameter int LEN_W   = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [X_W-1:0]   i_pos_x,
    input  logic [Y_W-1:0]   i_pos_y,
    input  logic             i_pos_first,
    input  logic             i_pos_last,
    input  logic             i_pos_valid,
    input  logic [X_W-1:0]   i_head_x,
    input  logic [Y_W-1:0]   i_head_y,
    output logic             o_synced,
    output logic             o_lap_done,
    output logic [LEN_W-1:0] o_length,
    output logic             o_self_hit,
    output logic             o_head_mismatch,
    output logic             o_proto_err
);

    localparam logic [LEN_W-1:0] MAX_CNT = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] ONE     = LEN_W'(1);

    mon_state_t       state, state_nxt;
    logic [LEN_W-1:0] count, count_nxt;
    logic [X_W-1:0]   head_x, head_x_nxt;
    logic [Y_W-1:0]   head_y, head_y_nxt;
    logic             hit, hit_nxt;
    logic             mis, mis_nxt;
    logic             lap_done_nxt;
    logic [LEN_W-1:0] length_nxt;
    logic             self_hit_nxt;
    logic             head_mis_nxt;
    logic             proto_err_nxt;
    logic             first_mis;
    logic             body_hit;

    assign o_synced = (state == LAP);

    // Register state, lap bookkeeping and the registered result outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= SYNC;
            count           <= '0;
            head_x          <= '0;
            head_y          <= '0;
            hit             <= 1'b0;
            mis             <= 1'b0;
            o_lap_done      <= 1'b0;
            o_length        <= '0;
            o_self_hit      <= 1'b0;
            o_head_mismatch <= 1'b0;
            o_proto_err     <= 1'b0;
        end else begin
            state           <= state_nxt;
            count           <= count_nxt;
            head_x          <= head_x_nxt;
            head_y          <= head_y_nxt;
            hit             <= hit_nxt;
            mis             <= mis_nxt;
            o_lap_done      <= lap_done_nxt;
            o_length        <= length_nxt;
            o_self_hit      <= self_hit_nxt;
            o_head_mismatch <= head_mis_nxt;
            o_proto_err     <= proto_err_nxt;
        end
    end

    // Next-state and lap-completion decisions for each valid beat.
    always_comb begin
        state_nxt     = state;
        count_nxt     = count;
        head_x_nxt    = head_x;
        head_y_nxt    = head_y;
        hit_nxt       = hit;
        mis_nxt       = mis;
        lap_done_nxt  = 1'b0;
        length_nxt    = o_length;
        self_hit_nxt  = o_self_hit;
        head_mis_nxt  = o_head_mismatch;
        proto_err_nxt = 1'b0;
        first_mis     = (i_pos_x != i_head_x) || (i_pos_y != i_head_y);
        body_hit      = (i_pos_x == head_x) && (i_pos_y == head_y);

        if (i_pos_valid) begin
            if (i_pos_first) begin
                // A first beat always restarts framing; inside a lap it is also an error.
                proto_err_nxt = (state == LAP);
                head_x_nxt    = i_pos_x;
                head_y_nxt    = i_pos_y;
                count_nxt     = ONE;
                hit_nxt       = 1'b0;
                mis_nxt       = first_mis;
                if (i_pos_last) begin
                    state_nxt    = SYNC;
                    lap_done_nxt = 1'b1;
                    length_nxt   = ONE;
                    self_hit_nxt = 1'b0;
                    head_mis_nxt = first_mis;
                end else begin
                    state_nxt = LAP;
                end
            end else if (state == LAP) begin
                if (count == MAX_CNT) begin
                    proto_err_nxt = 1'b1;
                    state_nxt     = SYNC;
                end else begin
                    count_nxt = count + ONE;
                    hit_nxt   = hit | body_hit;
                    if (i_pos_last) begin
                        state_nxt    = SYNC;
                        lap_done_nxt = 1'b1;
                        length_nxt   = count + ONE;
                        self_hit_nxt = hit | body_hit;
                        head_mis_nxt = mis;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_snake_stream_monitor.sv
// Self-checking bench for snake_stream_monitor: a default instance and a
// MAX_LEN=4 instance share one stimulus stream and are compared every cycle
// against a lap-queue reference model, plus constant-table and hand checks.
module tb_snake_stream_monitor;
    import snake_pkg::*;

    logic       clk;
    logic       rst_n;
    logic [4:0] i_pos_x;
    logic [3:0] i_pos_y;
    logic       i_pos_first;
    logic       i_pos_last;
    logic       i_pos_valid;
    logic [4:0] i_head_x;
    logic [3:0] i_head_y;

    logic       syn0, done0, hit0, mis0, err0;
    logic [9:0] len0;
    logic       syn1, done1, hit1, mis1, err1;
    logic [9:0] len1;

    int total = 0;
    int bad   = 0;

    snake_stream_monitor #(.X_W(5), .Y_W(4), .MAX_LEN(512), .LEN_W(10)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .i_pos_x(i_pos_x), .i_pos_y(i_pos_y),
        .i_pos_first(i_pos_first), .i_pos_last(i_pos_last), .i_pos_valid(i_pos_valid),
        .i_head_x(i_head_x), .i_head_y(i_head_y),
        .o_synced(syn0), .o_lap_done(done0), .o_length(len0),
        .o_self_hit(hit0), .o_head_mismatch(mis0), .o_proto_err(err0)
    );

    snake_stream_monitor #(.X_W(5), .Y_W(4), .MAX_LEN(4), .LEN_W(10)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .i_pos_x(i_pos_x), .i_pos_y(i_pos_y),
        .i_pos_first(i_pos_first), .i_pos_last(i_pos_last), .i_pos_valid(i_pos_valid),
        .i_head_x(i_head_x), .i_head_y(i_head_y),
        .o_synced(syn1), .o_lap_done(done1), .o_length(len1),
        .o_self_hit(hit1), .o_head_mismatch(mis1), .o_proto_err(err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    // ---------------- reference model: one lap kept as a queue ----------------
    pos_t lap_q [2][$];
    bit   in_lap [2];
    bit   lap_mis [2];
    bit   e_done [2];
    bit   e_err [2];
    bit   e_hit [2];
    bit   e_mis [2];
    int   e_len [2];

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            lap_q[m].delete();
            in_lap[m] = 0; lap_mis[m] = 0;
            e_done[m] = 0; e_err[m] = 0; e_hit[m] = 0; e_mis[m] = 0; e_len[m] = 0;
        end
    endtask

    task automatic finish_lap(int m);
        bit any_hit = 0;
        for (int i = 1; i < lap_q[m].size(); i++)
            if (lap_q[m][i] == lap_q[m][0]) any_hit = 1;
        e_done[m] = 1;
        e_len[m]  = lap_q[m].size();
        e_hit[m]  = any_hit;
        e_mis[m]  = lap_mis[m];
        in_lap[m] = 0;
    endtask

    task automatic model_beat(int m, int max_len, bit v, bit f, bit l, pos_t p, pos_t h);
        e_done[m] = 0;
        e_err[m]  = 0;
        if (v) begin
            if (f) begin
                e_err[m] = in_lap[m];
                lap_q[m].delete();
                lap_q[m].push_back(p);
                lap_mis[m] = (p != h);
                in_lap[m]  = 1;
                if (l) finish_lap(m);
            end else if (in_lap[m]) begin
                if (lap_q[m].size() >= max_len) begin
                    e_err[m]  = 1;
                    in_lap[m] = 0;
                end else begin
                    lap_q[m].push_back(p);
                    if (l) finish_lap(m);
                end
            end
        end
    endtask

    // ---------------- checking helpers ----------------
    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic compare_model();
        check("d0 synced",   32'(syn0),  32'(in_lap[0]));
        check("d0 lap_done", 32'(done0), 32'(e_done[0]));
        check("d0 length",   32'(len0),  32'(e_len[0]));
        check("d0 self_hit", 32'(hit0),  32'(e_hit[0]));
        check("d0 head_mis", 32'(mis0),  32'(e_mis[0]));
        check("d0 proto",    32'(err0),  32'(e_err[0]));
        check("d1 synced",   32'(syn1),  32'(in_lap[1]));
        check("d1 lap_done", 32'(done1), 32'(e_done[1]));
        check("d1 length",   32'(len1),  32'(e_len[1]));
        check("d1 self_hit", 32'(hit1),  32'(e_hit[1]));
        check("d1 head_mis", 32'(mis1),  32'(e_mis[1]));
        check("d1 proto",    32'(err1),  32'(e_err[1]));
    endtask

    // One clock: drive inputs, advance the model at the edge, compare just after.
    task automatic step(bit r, bit v, bit f, bit l, int x, int y, int hx, int hy);
        pos_t p, h;
        p.x = 5'(x);  p.y = 4'(y);
        h.x = 5'(hx); h.y = 4'(hy);
        rst_n = r; i_pos_valid = v; i_pos_first = f; i_pos_last = l;
        i_pos_x = p.x; i_pos_y = p.y; i_head_x = h.x; i_head_y = h.y;
        @(posedge clk);
        if (!r) model_reset();
        else begin
            model_beat(0, 512, v, f, l, p, h);
            model_beat(1, 4,   v, f, l, p, h);
        end
        #1;
        compare_model();
    endtask

    task automatic idle();
        step(1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // ---------------- constant vector table (default instance) ----------------
    typedef struct {
        bit v, f, l;
        int x, y, hx, hy;
        bit e_syn, e_done, e_err, e_hit, e_mis;
        int e_len;
    } vec_t;

    function automatic vec_t mk(bit v, bit f, bit l, int x, int y, int hx, int hy,
                                bit syn, bit dn, bit er, int ln, bit ht, bit ms);
        vec_t t;
        t.v = v; t.f = f; t.l = l; t.x = x; t.y = y; t.hx = hx; t.hy = hy;
        t.e_syn = syn; t.e_done = dn; t.e_err = er; t.e_len = ln; t.e_hit = ht; t.e_mis = ms;
        return t;
    endfunction

    vec_t vecs [14];

    initial begin
        //               v f l  x  y hx hy syn dn er len hit mis
        vecs[0]  = mk(1, 1, 0, 10, 5, 10, 5, 1, 0, 0, 0, 0, 0);
        vecs[1]  = mk(1, 0, 0,  9, 5, 10, 5, 1, 0, 0, 0, 0, 0);
        vecs[2]  = mk(1, 0, 1,  8, 5, 10, 5, 0, 1, 0, 3, 0, 0);
        vecs[3]  = mk(0, 0, 0,  0, 0, 10, 5, 0, 0, 0, 3, 0, 0);
        vecs[4]  = mk(1, 1, 1,  3, 3,  3, 3, 0, 1, 0, 1, 0, 0);
        vecs[5]  = mk(1, 1, 1,  3, 3,  3, 3, 0, 1, 0, 1, 0, 0);
        vecs[6]  = mk(1, 1, 1,  3, 3,  3, 3, 0, 1, 0, 1, 0, 0);
        vecs[7]  = mk(0, 0, 0,  0, 0,  3, 3, 0, 0, 0, 1, 0, 0);
        vecs[8]  = mk(1, 1, 0,  4, 4,  4, 4, 1, 0, 0, 1, 0, 0);
        vecs[9]  = mk(1, 0, 0,  5, 4,  4, 4, 1, 0, 0, 1, 0, 0);
        vecs[10] = mk(1, 0, 0,  5, 5,  4, 4, 1, 0, 0, 1, 0, 0);
        vecs[11] = mk(1, 0, 0,  4, 5,  4, 4, 1, 0, 0, 1, 0, 0);
        vecs[12] = mk(1, 0, 1,  4, 4,  4, 4, 0, 1, 0, 5, 1, 0);
        vecs[13] = mk(0, 0, 0,  0, 0,  4, 4, 0, 0, 0, 5, 1, 0);

        // Reset state
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        check("rst synced",   32'(syn0),  0);
        check("rst lap_done", 32'(done0), 0);
        check("rst length",   32'(len0),  0);
        check("rst proto",    32'(err0),  0);

        // Basic lap, back-to-back single-beat laps, self-hit lap
        for (int i = 0; i < 14; i++) begin
            step(1, vecs[i].v, vecs[i].f, vecs[i].l, vecs[i].x, vecs[i].y, vecs[i].hx, vecs[i].hy);
            check($sformatf("vec%0d synced", i),   32'(syn0),  32'(vecs[i].e_syn));
            check($sformatf("vec%0d lap_done", i), 32'(done0), 32'(vecs[i].e_done));
            check($sformatf("vec%0d proto", i),    32'(err0),  32'(vecs[i].e_err));
            check($sformatf("vec%0d length", i),   32'(len0),  32'(vecs[i].e_len));
            check($sformatf("vec%0d self_hit", i), 32'(hit0),  32'(vecs[i].e_hit));
            check($sformatf("vec%0d head_mis", i), 32'(mis0),  32'(vecs[i].e_mis));
        end

        // First without preceding last restarts the lap
        step(1, 1, 1, 0, 1, 1, 1, 1);
        step(1, 1, 0, 0, 2, 1, 1, 1);
        step(1, 1, 1, 0, 7, 7, 7, 7);
        check("restart proto", 32'(err0), 1);
        check("restart synced", 32'(syn0), 1);
        step(1, 1, 0, 1, 6, 7, 7, 7);
        check("restart proto clear", 32'(err0), 0);
        check("restart done", 32'(done0), 1);
        check("restart length", 32'(len0), 2);
        check("restart head_mis", 32'(mis0), 0);
        idle();

        // Start mid-stream: orphan beats, gaps inside lap, head register mismatch
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 9, 9, 0, 0);
        check("orphan synced", 32'(syn0), 0);
        check("orphan proto", 32'(err0), 0);
        step(1, 1, 0, 1, 8, 9, 0, 0);
        check("orphan last done", 32'(done0), 0);
        check("orphan last proto", 32'(err0), 0);
        step(1, 1, 1, 0, 1, 0, 0, 0);
        idle();
        step(1, 1, 0, 0, 2, 0, 0, 0);
        idle();
        idle();
        step(1, 1, 0, 0, 3, 0, 0, 0);
        step(1, 1, 0, 1, 4, 0, 0, 0);
        check("gap done", 32'(done0), 1);
        check("gap length", 32'(len0), 4);
        check("gap head_mis", 32'(mis0), 1);
        check("gap self_hit", 32'(hit0), 0);
        idle();

        // Length overflow on the MAX_LEN=4 instance
        step(1, 1, 1, 0, 0, 2, 0, 2);
        step(1, 1, 0, 0, 1, 2, 0, 2);
        step(1, 1, 0, 0, 2, 2, 0, 2);
        step(1, 1, 0, 0, 3, 2, 0, 2);
        check("max4 synced at 4", 32'(syn1), 1);
        step(1, 1, 0, 0, 4, 2, 0, 2);
        check("max4 proto", 32'(err1), 1);
        check("max4 synced", 32'(syn1), 0);
        check("max4 wide synced", 32'(syn0), 1);
        check("max4 wide proto", 32'(err0), 0);
        step(1, 1, 0, 1, 5, 2, 0, 2);
        check("max4 no done after err", 32'(done1), 0);
        check("max4 wide done", 32'(done0), 1);
        check("max4 wide length", 32'(len0), 6);

        // Reset mid-lap discards the lap silently
        step(1, 1, 1, 0, 6, 6, 6, 6);
        step(1, 1, 0, 0, 7, 6, 6, 6);
        step(0, 1, 0, 1, 8, 6, 6, 6);
        check("midrst synced", 32'(syn0), 0);
        check("midrst done", 32'(done0), 0);
        check("midrst proto", 32'(err0), 0);
        check("midrst length", 32'(len0), 0);
        check("midrst d1 synced", 32'(syn1), 0);
        idle();
        check("midrst after done", 32'(done0), 0);
        check("midrst after proto", 32'(err0), 0);

        // Randomized traffic against the reference model
        for (int n = 0; n < 4000; n++) begin
            int x, y;
            bit r, v, f, l, same;
            r    = ($urandom_range(149) != 0);
            v    = ($urandom_range(9) < 7);
            f    = ($urandom_range(9) < 2);
            l    = ($urandom_range(9) < 2);
            x    = $urandom_range(3);
            y    = $urandom_range(3);
            same = ($urandom_range(1) == 1);
            if (same) step(r, v, f, l, x, y, x, y);
            else      step(r, v, f, l, x, y, $urandom_range(3), $urandom_range(3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
